// File: rtl/control_unit_pipelined_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_pipelined_if
//  Description : Bundle of the decode-slot handshake and the registered
//                execute-stage control bus of control_unit_pipelined.
//                master : instruction source / control consumer
//                slave  : the control unit
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    in_valid, in_ready         decode-slot handshake
//    mode, opcode, s,
//    immediate_in, cond         instruction fields
//    status                     committed flags {N,Z,C,V}
//    ex_stall                   execute stage frozen
//    out_valid .. flush_active  registered control outputs
// ============================================================================
interface control_unit_pipelined_if #(
  parameter int MODE_W     = 2,
  parameter int OPCODE_W   = 4,
  parameter int EXEC_CMD_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [MODE_W-1:0]     mode;
  logic [OPCODE_W-1:0]   opcode;
  logic                  s;
  logic                  immediate_in;
  logic [3:0]            cond;
  logic [3:0]            status;
  logic                  ex_stall;

  logic                  out_valid;
  logic [EXEC_CMD_W-1:0] execute_command;
  logic                  mem_read;
  logic                  mem_write;
  logic                  wb_enable;
  logic                  immediate;
  logic                  branch_taken;
  logic                  status_write_enable;
  logic                  flush_active;

  modport master (
    output in_valid, mode, opcode, s, immediate_in, cond, status, ex_stall,
    input  in_ready, out_valid, execute_command, mem_read, mem_write,
           wb_enable, immediate, branch_taken, status_write_enable,
           flush_active
  );

  modport slave (
    input  in_valid, mode, opcode, s, immediate_in, cond, status, ex_stall,
    output in_ready, out_valid, execute_command, mem_read, mem_write,
           wb_enable, immediate, branch_taken, status_write_enable,
           flush_active
  );
endinterface
`default_nettype wire

// File: rtl/control_unit_pipelined.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_pipelined
//  Description : Combinational instruction decoder with condition gating,
//                followed by a one-stage registered control output. Handles
//                a status-flag hazard (one bubble after a flag-writing
//                instruction when the next one is conditional), execute
//                stall, and squashing of FLUSH_DEPTH instructions after a
//                taken branch.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk  : rising-edge clock
//    rst  : asynchronous active-high reset
//    bus  : control_unit_pipelined_if.slave (handshake, fields, controls)
// ============================================================================
module control_unit_pipelined #(
  parameter int MODE_W      = 2,
  parameter int OPCODE_W    = 4,
  parameter int EXEC_CMD_W  = 4,
  parameter int FLUSH_DEPTH = 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  control_unit_pipelined_if.slave    bus
);

  localparam int CNT_W = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  localparam logic [MODE_W-1:0]   C_MODE_ARITH  = MODE_W'(0);
  localparam logic [MODE_W-1:0]   C_MODE_MEM    = MODE_W'(1);
  localparam logic [MODE_W-1:0]   C_MODE_BRANCH = MODE_W'(2);

  localparam logic [OPCODE_W-1:0] C_OP_MOV = OPCODE_W'(4'b1101);
  localparam logic [OPCODE_W-1:0] C_OP_MVN = OPCODE_W'(4'b1111);
  localparam logic [OPCODE_W-1:0] C_OP_ADD = OPCODE_W'(4'b0100);
  localparam logic [OPCODE_W-1:0] C_OP_ADC = OPCODE_W'(4'b0101);
  localparam logic [OPCODE_W-1:0] C_OP_SUB = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] C_OP_SBC = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] C_OP_AND = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] C_OP_ORR = OPCODE_W'(4'b1100);
  localparam logic [OPCODE_W-1:0] C_OP_EOR = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] C_OP_CMP = OPCODE_W'(4'b1010);
  localparam logic [OPCODE_W-1:0] C_OP_TST = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0] C_OP_MEM = OPCODE_W'(4'b0100);

  localparam logic [3:0] C_COND_AL = 4'b1110;

  // --------------------------------------------------------------------------
  // Decode (combinational)
  // --------------------------------------------------------------------------
  logic [EXEC_CMD_W-1:0] dec_cmd;
  logic                  dec_mem_read;
  logic                  dec_mem_write;
  logic                  dec_wb;
  logic                  dec_imm;
  logic                  dec_branch;
  logic                  dec_swe;
  logic                  arith_known;
  logic                  arith_cmp_tst;

  always_comb begin
    dec_cmd       = '0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_wb        = 1'b0;
    dec_imm       = 1'b0;
    dec_branch    = 1'b0;
    dec_swe       = 1'b0;
    arith_known   = 1'b1;
    arith_cmp_tst = 1'b0;

    if (bus.mode == C_MODE_ARITH) begin
      case (bus.opcode)
        C_OP_MOV: dec_cmd = EXEC_CMD_W'(4'b0001);
        C_OP_MVN: dec_cmd = EXEC_CMD_W'(4'b1001);
        C_OP_ADD: dec_cmd = EXEC_CMD_W'(4'b0010);
        C_OP_ADC: dec_cmd = EXEC_CMD_W'(4'b0011);
        C_OP_SUB: dec_cmd = EXEC_CMD_W'(4'b0100);
        C_OP_SBC: dec_cmd = EXEC_CMD_W'(4'b0101);
        C_OP_AND: dec_cmd = EXEC_CMD_W'(4'b0110);
        C_OP_ORR: dec_cmd = EXEC_CMD_W'(4'b0111);
        C_OP_EOR: dec_cmd = EXEC_CMD_W'(4'b1000);
        C_OP_CMP: begin
          dec_cmd       = EXEC_CMD_W'(4'b0100);
          arith_cmp_tst = 1'b1;
        end
        C_OP_TST: begin
          dec_cmd       = EXEC_CMD_W'(4'b0110);
          arith_cmp_tst = 1'b1;
        end
        default:  arith_known = 1'b0;
      endcase
      // Unknown opcodes fall through as a NOP with every control left at 0.
      if (arith_known) begin
        dec_wb  = !arith_cmp_tst;
        dec_swe = bus.s | arith_cmp_tst;
        dec_imm = bus.immediate_in;
      end
    end else if (bus.mode == C_MODE_MEM) begin
      if (bus.opcode == C_OP_MEM) begin
        dec_cmd       = EXEC_CMD_W'(4'b0010);
        dec_imm       = bus.immediate_in;
        dec_mem_read  = bus.s;
        dec_wb        = bus.s;
        dec_mem_write = !bus.s;
      end
    end else if (bus.mode == C_MODE_BRANCH) begin
      dec_branch = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Condition evaluation against committed flags {N,Z,C,V}
  // --------------------------------------------------------------------------
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = bus.status;

  always_comb begin
    cond_pass = 1'b0;
    case (bus.cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c & !flag_z;
      4'b1001: cond_pass = !flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Handshake and hazard
  // --------------------------------------------------------------------------
  logic                  out_valid_q,    out_valid_d;
  logic [EXEC_CMD_W-1:0] exec_cmd_q,     exec_cmd_d;
  logic                  mem_read_q,     mem_read_d;
  logic                  mem_write_q,    mem_write_d;
  logic                  wb_enable_q,    wb_enable_d;
  logic                  immediate_q,    immediate_d;
  logic                  branch_taken_q, branch_taken_d;
  logic                  swe_q,          swe_d;
  logic [CNT_W-1:0]      flush_cnt_q,    flush_cnt_d;

  logic status_hazard;
  logic in_ready;
  logic accept;
  logic flush_active;

  // The instruction in the output register has not yet committed its flags,
  // so a conditional instruction must wait one cycle for them to settle.
  assign status_hazard = out_valid_q & swe_q & (bus.cond != C_COND_AL);
  assign in_ready      = !rst & !bus.ex_stall & !status_hazard;
  assign accept        = bus.in_valid & in_ready;
  assign flush_active  = (flush_cnt_q != '0);

  // --------------------------------------------------------------------------
  // Next-state of output register and flush counter
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid_d    = out_valid_q;
    exec_cmd_d     = exec_cmd_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    wb_enable_d    = wb_enable_q;
    immediate_d    = immediate_q;
    branch_taken_d = branch_taken_q;
    swe_d          = swe_q;
    flush_cnt_d    = flush_cnt_q;

    if (!bus.ex_stall) begin
      // Bubble unless a live instruction is accepted below.
      out_valid_d    = 1'b0;
      exec_cmd_d     = '0;
      mem_read_d     = 1'b0;
      mem_write_d    = 1'b0;
      wb_enable_d    = 1'b0;
      immediate_d    = 1'b0;
      branch_taken_d = 1'b0;
      swe_d          = 1'b0;

      if (accept && flush_active) begin
        // Squashed: consumes one slot of the shadow, never loads a branch.
        flush_cnt_d = flush_cnt_q - CNT_W'(1);
      end else if (accept) begin
        // A failed condition still retires as a valid, control-less slot.
        out_valid_d    = 1'b1;
        exec_cmd_d     = cond_pass ? dec_cmd : '0;
        mem_read_d     = cond_pass & dec_mem_read;
        mem_write_d    = cond_pass & dec_mem_write;
        wb_enable_d    = cond_pass & dec_wb;
        immediate_d    = cond_pass & dec_imm;
        branch_taken_d = cond_pass & dec_branch;
        swe_d          = cond_pass & dec_swe;
        if (cond_pass & dec_branch) begin
          flush_cnt_d = CNT_W'(FLUSH_DEPTH);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      exec_cmd_q     <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      wb_enable_q    <= 1'b0;
      immediate_q    <= 1'b0;
      branch_taken_q <= 1'b0;
      swe_q          <= 1'b0;
      flush_cnt_q    <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      exec_cmd_q     <= exec_cmd_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      wb_enable_q    <= wb_enable_d;
      immediate_q    <= immediate_d;
      branch_taken_q <= branch_taken_d;
      swe_q          <= swe_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.in_ready            = in_ready;
  assign bus.out_valid           = out_valid_q;
  assign bus.execute_command     = exec_cmd_q;
  assign bus.mem_read            = mem_read_q;
  assign bus.mem_write           = mem_write_q;
  assign bus.wb_enable           = wb_enable_q;
  assign bus.immediate           = immediate_q;
  assign bus.branch_taken        = branch_taken_q;
  assign bus.status_write_enable = swe_q;
  assign bus.flush_active        = flush_active;

endmodule
`default_nettype wire

// File: doc/control_unit_pipelined.md
CONTROL_UNIT_PIPELINED -- requirements
Module: control_unit_pipelined

Interface
REQ-001 The block SHALL have parameter MODE_W, default 2, mode field width.
REQ-002 The block SHALL have parameter OPCODE_W, default 4, opcode field width.
REQ-003 The block SHALL have parameter EXEC_CMD_W, default 4, execute_command width.
REQ-004 The block SHALL have parameter FLUSH_DEPTH, default 1, instructions squashed after a taken branch; 0 disables squashing.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk input 1 (rising-edge clock) and rst input 1 (asynchronous active-high reset).
REQ-006 Data inputs SHALL be: in_valid input 1 (decode-slot instruction valid); mode input MODE_W; opcode input OPCODE_W; s input 1; immediate_in input 1; cond input 4; status input 4 ({N,Z,C,V}, committed flags); ex_stall input 1 (execute stage frozen).
REQ-007 Outputs SHALL be: in_ready output 1 (instruction accepted this cycle); out_valid output 1; execute_command output EXEC_CMD_W; mem_read, mem_write, wb_enable, immediate, branch_taken, status_write_enable output 1 each; flush_active output 1.

Function
REQ-008 Decode SHALL be combinational; mode 00 arithmetic, 01 memory, 10 branch, 11 invalid.
REQ-009 Arithmetic opcodes SHALL map to execute_command as MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
REQ-010 All arithmetic opcodes except CMP/TST SHALL set wb_enable=1; CMP/TST SHALL set wb_enable=0; status_write_enable SHALL equal s, forced 1 for CMP/TST.
REQ-011 Memory mode with opcode 0100 SHALL decode as LDR (s=1: mem_read=1, wb_enable=1) or STR (s=0: mem_write=1), execute_command 0010, status_write_enable 0.
REQ-012 Branch mode SHALL set branch_taken=1, all other controls 0; immediate SHALL equal immediate_in for arithmetic and memory modes only.
REQ-013 Unlisted opcode or mode 11 SHALL decode as NOP: all controls and execute_command 0.
REQ-014 Condition SHALL be evaluated from status: EQ 0000 Z, NE 0001 !Z, CS 0010 C, CC 0011 !C, MI 0100 N, PL 0101 !N, VS 0110 V, VC 0111 !V, HI 1000 C&!Z, LS 1001 !C|Z, GE 1010 N==V, LT 1011 N!=V, GT 1100 !Z&(N==V), LE 1101 Z|(N!=V), AL 1110 true, 1111 false.
REQ-015 A failed condition SHALL gate all controls to 0 while the instruction still produces out_valid=1.
REQ-016 in_ready SHALL be !rst & !ex_stall & !status_hazard; acceptance is in_valid & in_ready.
REQ-017 status_hazard SHALL be out_valid & status_write_enable (registered) & cond!=1110; the instruction then waits and a bubble is inserted.
REQ-018 On each clock with ex_stall=0, the output register SHALL load the decoded, gated controls with out_valid=1 if accepted, else a bubble (out_valid=0, all controls 0).
REQ-019 With ex_stall=1 the output register and flush counter SHALL hold unchanged.
REQ-020 The flush counter SHALL load FLUSH_DEPTH on the edge a branch_taken=1 instruction enters the output register; flush_active SHALL be counter!=0.
REQ-021 While flush_active, each accepted instruction SHALL decrement the counter and be loaded as a bubble (out_valid=0).
REQ-022 Squashed instructions SHALL never load branch_taken, so a squashed branch does not reload the counter.
REQ-023 Latency SHALL be one cycle from acceptance to out_valid.

Reset
REQ-024 While rst=1 (asynchronous), out_valid, execute_command, all controls, the flush counter and flush_active SHALL be 0 and in_ready SHALL be 0.
REQ-025 Reset asserted mid-flush or mid-stall SHALL discard the in-flight instruction and counter; the first edge after deassertion SHALL accept normally.

Verification
REQ-026 A bench SHALL drive ADD (mode 00, opcode 0100, s=1, cond 1110, imm 1) -> next cycle out_valid=1, execute_command 0010, wb_enable=1, status_write_enable=1, immediate=1.
REQ-027 A bench SHALL drive CMP s=1 followed by MOV cond EQ -> in_ready=0 for one cycle, bubble out, then MOV issues with Z-based gating using the updated status.
REQ-028 A bench SHALL drive branch cond AL, then two ADDs with FLUSH_DEPTH=1 -> first ADD out_valid=0, second out_valid=1, flush_active high exactly one accepted instruction.
REQ-029 A bench SHALL drive LDR (mode 01, opcode 0100, s=1) with status Z=0, cond EQ -> out_valid=1, all controls 0.
REQ-030 A bench SHALL hold ex_stall=1 for 3 cycles with STR in the output register -> outputs held, in_ready=0; rst pulse mid-stall clears all outputs asynchronously.
